// File: rtl/control_decode_execute.sv
// Decode, register file and ALU execute for the 16-bit in-order pipeline.
// Two register stages: decode latch (_p0), then the registered ex_* outputs.
module control_decode_execute #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    ir,
  input  logic [DATA_W-1:0]    pc,
  input  logic                 wb_regwrite,
  input  logic [RADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  output logic                 pcwrite,
  output logic [DATA_W-1:0]    ex_pc,
  output logic [DATA_W-1:0]    ex_aluout,
  output logic [DATA_W-1:0]    ex_bout,
  output logic [RADDR_W-1:0]   ex_rdout,
  output logic                 ex_zero,
  output logic                 ex_pos,
  output logic                 ex_memread,
  output logic                 ex_memwrite,
  output logic                 ex_mem2reg,
  output logic                 ex_regwrite
);
  localparam int NREG = 1 << RADDR_W;

  function automatic logic signed [DATA_W-1:0] immgen(input logic [DATA_W-1:0] i,
                                                      input logic [1:0] sel);
    case (sel)
      2'b00:   return DATA_W'($signed(i[7:4]));
      2'b01:   return DATA_W'($signed(i[11:4]));
      2'b10:   return DATA_W'($signed(i[15:12]));
      default: return {i[11:4], 8'h00};
    endcase
  endfunction

  logic [3:0]         op;
  logic [RADDR_W-1:0] rd, rs1, rs2;
  assign op  = ir[3:0];
  assign rd  = ir[15:12];
  assign rs1 = ir[11:8];
  assign rs2 = ir[7:4];

  assign pcwrite = !rst && (op != 4'd15);

  logic       regwrite_d, memread_d, memwrite_d, mem2reg_d, aluop_d, aluin1_d;
  logic [1:0] aluin2_d, immgenop_d;

  always_comb begin
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    mem2reg_d  = 1'b0;
    aluop_d    = 1'b0;
    aluin1_d   = 1'b0;
    aluin2_d   = 2'b00;
    immgenop_d = 2'b00;
    case (op)
      4'd0: regwrite_d = 1'b1;
      4'd1: begin aluop_d = 1'b1; regwrite_d = 1'b1; end
      4'd2: begin aluin2_d = 2'b01; regwrite_d = 1'b1; end
      4'd3: begin aluin2_d = 2'b01; memread_d = 1'b1; mem2reg_d = 1'b1; regwrite_d = 1'b1; end
      4'd4: begin immgenop_d = 2'b10; aluin2_d = 2'b01; memwrite_d = 1'b1; end
      4'd5: begin immgenop_d = 2'b01; aluin2_d = 2'b01; regwrite_d = 1'b1; end
      4'd6: begin immgenop_d = 2'b11; aluin2_d = 2'b01; regwrite_d = 1'b1; end
      4'd7: begin immgenop_d = 2'b01; aluin1_d = 1'b1; aluin2_d = 2'b11; regwrite_d = 1'b1; end
      4'd8: aluop_d = 1'b1;
      default: ;
    endcase
  end

  // Register file with write-first bypass; r0 is hardwired to zero.
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] rf_a, rf_b, a_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_regwrite && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  assign rf_a = (rs1 == '0) ? '0 : (wb_regwrite && wb_rd == rs1) ? wb_data : rf[rs1];
  assign rf_b = (rs2 == '0) ? '0 : (wb_regwrite && wb_rd == rs2) ? wb_data : rf[rs2];
  // The wide immediate forms reuse the rs1 field, so A must not leak in.
  assign a_d  = immgenop_d[0] ? '0 : rf_a;

  // ---- decode -> execute boundary ----
  logic signed [DATA_W-1:0] a_p0, b_p0, imm_p0;
  logic [DATA_W-1:0]        pc_p0;
  logic [RADDR_W-1:0]       rd_p0;
  logic                     aluop_p0, aluin1_p0;
  logic [1:0]               aluin2_p0;
  logic                     regwrite_p0, memread_p0, memwrite_p0, mem2reg_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0 <= '0; b_p0 <= '0; imm_p0 <= '0; pc_p0 <= '0; rd_p0 <= '0;
      aluop_p0 <= 1'b0; aluin1_p0 <= 1'b0; aluin2_p0 <= 2'b00;
      regwrite_p0 <= 1'b0; memread_p0 <= 1'b0; memwrite_p0 <= 1'b0; mem2reg_p0 <= 1'b0;
    end else begin
      a_p0 <= a_d; b_p0 <= rf_b; imm_p0 <= immgen(ir, immgenop_d); pc_p0 <= pc; rd_p0 <= rd;
      aluop_p0 <= aluop_d; aluin1_p0 <= aluin1_d; aluin2_p0 <= aluin2_d;
      regwrite_p0 <= regwrite_d; memread_p0 <= memread_d;
      memwrite_p0 <= memwrite_d; mem2reg_p0 <= mem2reg_d;
    end
  end

  logic signed [DATA_W-1:0] in1_x, in2_x, alu_x;

  always_comb begin
    in1_x = aluin1_p0 ? $signed(pc_p0) : a_p0;
    case (aluin2_p0)
      2'b00:   in2_x = b_p0;
      2'b01:   in2_x = imm_p0;
      2'b10:   in2_x = DATA_W'(2);
      default: in2_x = imm_p0 <<< 1;
    endcase
    alu_x = aluop_p0 ? (in1_x - in2_x) : (in1_x + in2_x);
  end

  // ---- execute -> memory boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc <= '0; ex_aluout <= '0; ex_bout <= '0; ex_rdout <= '0;
      ex_zero <= 1'b1; ex_pos <= 1'b0;
      ex_memread <= 1'b0; ex_memwrite <= 1'b0; ex_mem2reg <= 1'b0; ex_regwrite <= 1'b0;
    end else begin
      ex_pc <= pc_p0; ex_aluout <= alu_x; ex_bout <= b_p0; ex_rdout <= rd_p0;
      ex_zero <= (alu_x == '0); ex_pos <= (alu_x > 0);
      ex_memread <= memread_p0; ex_memwrite <= memwrite_p0;
      ex_mem2reg <= mem2reg_p0; ex_regwrite <= regwrite_p0;
    end
  end
endmodule

// File: tb/tb_control_decode_execute.sv
// Directed bench for control_decode_execute: hand-computed vectors, checked
// with immediate assertions one step at a time.
module tb_control_decode_execute;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ir, pc;
  logic        wb_regwrite;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        pcwrite;
  logic [15:0] ex_pc, ex_aluout, ex_bout;
  logic [3:0]  ex_rdout;
  logic        ex_zero, ex_pos, ex_memread, ex_memwrite, ex_mem2reg, ex_regwrite;

  int passed = 0;
  int total  = 0;

  localparam logic [15:0] NOP = 16'h0009;

  control_decode_execute dut (
    .clk(clk), .rst(rst), .ir(ir), .pc(pc),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .pcwrite(pcwrite), .ex_pc(ex_pc), .ex_aluout(ex_aluout), .ex_bout(ex_bout),
    .ex_rdout(ex_rdout), .ex_zero(ex_zero), .ex_pos(ex_pos),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_mem2reg(ex_mem2reg), .ex_regwrite(ex_regwrite)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // enables packed as {memread, memwrite, mem2reg, regwrite}
  function automatic logic [3:0] ens();
    return {ex_memread, ex_memwrite, ex_mem2reg, ex_regwrite};
  endfunction

  // Present one instruction, follow with a nop; results are then on ex_*.
  task automatic run(input logic [15:0] instr, input logic [15:0] pcv);
    ir = instr; pc = pcv;
    tick();
    ir = NOP;
    tick();
  endtask

  task automatic wb(input logic [3:0] r, input logic [15:0] d);
    wb_regwrite = 1'b1; wb_rd = r; wb_data = d;
    tick();
    wb_regwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ir = 16'h0000; pc = 16'h0000;
    wb_regwrite = 1'b0; wb_rd = 4'd0; wb_data = 16'h0000;
    #1;
    chk("pcwrite_in_reset", pcwrite, 1'b0);
    tick();
    tick();
    chk("reset_aluout", ex_aluout, 16'h0000);
    chk("reset_zero", ex_zero, 1'b1);
    chk("reset_enables", ens(), 4'b0000);
    chk("reset_pc", ex_pc, 16'h0000);
    rst = 1'b0;

    // li r1, 0xFD -> sign-extended
    run(16'h1FD5, 16'h0000);
    chk("li_aluout", ex_aluout, 16'hFFFD);
    chk("li_rdout", ex_rdout, 4'd1);
    chk("li_regwrite", ex_regwrite, 1'b1);
    chk("li_pos", ex_pos, 1'b0);
    chk("li_zero", ex_zero, 1'b0);

    // write-first bypass: r2=5 written in the same cycle as add r3,r2,r2
    wb_regwrite = 1'b1; wb_rd = 4'd2; wb_data = 16'h0005;
    ir = 16'h3220;
    tick();
    wb_regwrite = 1'b0; ir = NOP;
    tick();
    chk("bypass_add", ex_aluout, 16'h000A);
    run(16'h3200, 16'h0000);
    chk("r2_stored", ex_aluout, 16'h0005);

    // r0 is never written
    wb(4'd0, 16'h1234);
    run(16'h4000, 16'h0000);
    chk("r0_add", ex_aluout, 16'h0000);
    chk("r0_zero", ex_zero, 1'b1);

    wb(4'd1, 16'h0003);
    wb(4'd2, 16'h0005);
    run(16'h7121, 16'h0000);
    chk("sub_aluout", ex_aluout, 16'hFFFE);
    chk("sub_flags", {ex_pos, ex_zero}, 2'b00);
    run(16'h0218, 16'h0000);
    chk("cmp_aluout", ex_aluout, 16'h0002);
    chk("cmp_pos", ex_pos, 1'b1);
    chk("cmp_regwrite", ex_regwrite, 1'b0);
    run(16'h0118, 16'h0000);
    chk("cmp_eq_aluout", ex_aluout, 16'h0000);
    chk("cmp_eq_zero", ex_zero, 1'b1);

    wb(4'd1, 16'h0100);
    wb(4'd6, 16'hBEEF);
    run(16'h51F3, 16'h0000);
    chk("lw_aluout", ex_aluout, 16'h00FF);
    chk("lw_enables", ens(), 4'b1011);
    chk("lw_rdout", ex_rdout, 4'd5);
    run(16'h2164, 16'h0000);
    chk("sw_aluout", ex_aluout, 16'h0102);
    chk("sw_bout", ex_bout, 16'hBEEF);
    chk("sw_enables", ens(), 4'b0100);

    run(16'h7037, 16'h0040);
    chk("auipc_aluout", ex_aluout, 16'h0046);
    chk("auipc_pc", ex_pc, 16'h0040);
    run(16'h8AB6, 16'h0000);
    chk("lui_aluout", ex_aluout, 16'hAB00);

    ir = 16'h123F;
    #1;
    chk("halt_pcwrite", pcwrite, 1'b0);
    tick();
    ir = NOP;
    tick();
    chk("halt_enables", ens(), 4'b0000);
    ir = 16'h1239;
    #1;
    chk("nop_pcwrite", pcwrite, 1'b1);
    tick();
    tick();
    chk("nop_enables", ens(), 4'b0000);

    // back-to-back li r1..r3 with 1,2,3
    ir = 16'h1015; tick();
    ir = 16'h2025; tick();
    chk("b2b_0", {ex_rdout, ex_aluout}, {4'd1, 16'h0001});
    ir = 16'h3035; tick();
    chk("b2b_1", {ex_rdout, ex_aluout}, {4'd2, 16'h0002});
    ir = NOP; tick();
    chk("b2b_2", {ex_rdout, ex_aluout}, {4'd3, 16'h0003});

    // mid-stream reset flushes both in-flight instructions and clears registers
    ir = 16'h1125; tick();
    rst = 1'b1; ir = 16'h2345; tick();
    rst = 1'b0; ir = NOP;
    chk("flush_aluout", ex_aluout, 16'h0000);
    chk("flush_enables", {ens(), ex_zero}, 5'b00001);
    tick();
    chk("flush_second", {ex_regwrite, ex_aluout}, {1'b0, 16'h0000});
    run(16'h3160, 16'h0000);
    chk("regs_cleared", ex_aluout, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/control_decode_execute.md
Name: control_decode_execute

Overview:
- Front half of the 16-bit in-order pipeline: instruction control decode, register-file read/writeback, immediate generation and the ALU execute stage.
- Takes the fetched instruction/PC from the fetch→decode latch and writeback data from the mem→writeback stage.
- Produces registered execute-stage results plus the memory/writeback control bits for the downstream memory stage.

Parameters:
- DATA_W, 16, datapath/instruction width; only 16 supported.
- RADDR_W, 4, register index width; 16 registers.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ir  in  16  instruction in decode stage
- pc  in  16  PC of that instruction
- wb_regwrite  in  1  writeback enable
- wb_rd  in  4  writeback register index
- wb_data  in  16  writeback data
- pcwrite  out  1  PC update enable to fetch (combinational)
- ex_pc  out  16  PC of instruction in execute
- ex_aluout  out  16  ALU result
- ex_bout  out  16  rs2 value passed to memory (store data)
- ex_rdout  out  4  destination index
- ex_zero  out  1  ex_aluout == 0
- ex_pos  out  1  ex_aluout signed > 0
- ex_memread, ex_memwrite, ex_mem2reg, ex_regwrite  out  1 each  downstream controls

Behaviour:
- Fields: op=ir[3:0], rd=ir[15:12], rs1=ir[11:8], rs2=ir[7:4].
- immgenop (internal, 2b):
  - 00 sext(ir[7:4])
  - 01 sext(ir[11:4])
  - 10 sext(ir[15:12])
  - 11 {ir[11:4],8'h00}
- aluin1: 0=A, 1=PC. aluin2: 00=B, 01=imm, 10=16'd2, 11=imm<<1. aluop: 0=add, 1=sub (in1−in2). All arithmetic modulo 2^16.
- Opcodes (control, combinational from op):
  - 0 add: A+B, regwrite
  - 1 sub: A−B, regwrite
  - 2 addi: A+imm(00), regwrite
  - 3 lw: A+imm(00), memread, mem2reg=1, regwrite
  - 4 sw: A+imm(10), memwrite, rd field not written
  - 5 li: 0+imm(01), regwrite
  - 6 lui: 0+imm(11), regwrite
  - 7 auipc: PC+(imm(01)<<1), regwrite
  - 8 cmp: A−B, no writes (flags only)
  - 15 halt: no writes, pcwrite=0
  - 9–14: nop (all enables 0, ALU add)
- For immgenop 01/11, A operand is forced to 0.
- pcwrite = 0 when rst or op==15, else 1.
- mem2reg=1 selects memory data at writeback; 0 selects ALU. mem2reg=0 for all non-load ops.
- Register file: 16×16.
  - r0 reads 0 and is never written.
  - Write on posedge clk when wb_regwrite && wb_rd!=0.
  - Same-cycle read of the written register returns wb_data (write-first bypass).
- Decode stage (posedge): latch A, B, imm, rd, pc, aluop, aluin1, aluin2 and the four downstream enables into the D/E register.
- Execute stage (posedge): compute ALU from D/E contents; latch aluout, bout=B, rdout, pc, zero, pos and the enables into the outputs.
- zero/pos are derived from the same result being latched, so they are aligned with ex_aluout.
- Latency: instruction presented on ir at edge N appears on ex_* after edge N+2. Throughput one instruction per cycle; no stalls or handshake.
- Reset (sync): D/E and execute registers cleared to 0, i.e. nop bubble.
  - All ex_* = 0 except ex_zero = 1, since aluout = 0.
  - All registers r1–r15 cleared to 0.
  - Reset asserted mid-stream discards both in-flight instructions.
- Undefined fields of nop/halt are ignored.

Test Plan:
- Reset: hold rst 1 cycle.
  - Expect ex_aluout=0, ex_zero=1, all enables 0, pcwrite=0 during rst.
  - Then li r1 with ir[11:4]=0xFD → after 2 edges ex_aluout=0xFFFD, ex_rdout=1, ex_regwrite=1, ex_pos=0.
- Writeback/bypass:
  - wb_regwrite=1, wb_rd=2, wb_data=0x0005 in the same cycle as "add r3,r2,r2" → ex_aluout=0x000A.
  - wb_rd=0, wb_data=0x1234 then "add r4,r0,r0" → ex_aluout=0, ex_zero=1.
- Sub/cmp flags, with r1=3 and r2=5:
  - "sub" r1−r2 → ex_aluout=0xFFFE, pos=0, zero=0.
  - "cmp" r2−r1 → ex_aluout=2, pos=1, ex_regwrite=0.
  - "cmp" r1−r1 → ex_aluout=0, zero=1.
- Load/store, with r1=0x0100 and r6=0xBEEF:
  - "lw r5,-1(r1)", imm4=0xF → ex_aluout=0x00FF, memread=1, mem2reg=1, regwrite=1.
  - "sw r6, 2(r1)", ir[15:12]=2 → ex_aluout=0x0102, ex_bout=0xBEEF, memwrite=1, regwrite=0.
- PC/upper immediates:
  - pc=0x0040, auipc imm8=0x03 → ex_aluout=0x0046, ex_pc=0x0040.
  - lui imm8=0xAB → 0xAB00.
- Halt/nop:
  - op=15 → pcwrite=0 combinationally, ex_* enables 0 after 2 edges.
  - op=9 → pcwrite=1, all enables 0.
  - Back-to-back instructions each emerge on consecutive cycles.
